// File: rtl/day3_pkg.sv
// -----------------------------------------------------------------------------
// day3_pkg
// Shared definitions for the day-3 digit pipeline: ASCII byte constants,
// the finder result width, and the line_digit_packer state encoding.
// -----------------------------------------------------------------------------
package day3_pkg;

   // ASCII bytes recognised in the puzzle stream
   localparam logic [7:0] CH_0  = 8'h30;
   localparam logic [7:0] CH_9  = 8'h39;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;

   // Width of one per-line result from the highest-digit finder
   localparam int RESULT_W = 40;

   // Packer state encoding
   localparam logic [2:0] COLLECT = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] CLEAR   = 3'd3;
   localparam logic [2:0] FINAL   = 3'd4;

   typedef enum logic [2:0] {
      ST_COLLECT = COLLECT,
      ST_ISSUE   = ISSUE,
      ST_WAIT    = WAIT,
      ST_CLEAR   = CLEAR,
      ST_FINAL   = FINAL
   } state_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= CH_0) && (b <= CH_9);
   endfunction

endpackage

// File: rtl/line_digit_packer.sv
// -----------------------------------------------------------------------------
// line_digit_packer
// Front end of the day-3 highest-digit finder. Packs the digits of each ASCII
// line into a 4-bit-per-digit vector (rightmost character in bits [3:0]),
// hands the vector to the finder with a start pulse, waits for its finished
// level, accumulates the finder result into a running total and clears the
// finder before the next line. done_o rises once the stream has ended.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/in_data/in_last/in_ready   byte stream input (valid/ready)
//   num_o           packed digit vector, held stable while the finder runs
//   start_o         one-cycle start pulse to the finder
//   finished_i      finder result-valid level
//   result_i        finder per-line result
//   finder_clr_o    one-cycle clear returning the finder to idle
//   total_o         running (wrapping) sum of line results
//   lines_o         number of lines processed (wrapping)
//   overflow_o      sticky: a line had more than MAX_DIGITS digits
//   done_o          stream complete, held until reset
//
// Optional build macro LINE_PACKER_WDOG_EN adds a finder timeout: after
// WDOG_CYCLES cycles in WAIT the line is skipped and sticky wdog_err_o is set.
// -----------------------------------------------------------------------------
module line_digit_packer
   import day3_pkg::*;
#(
   parameter int WIDTH       = 400,
   parameter int MAX_DIGITS  = WIDTH / 4,
   parameter int SUM_W       = 48,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [7:0]          in_data,
   input  logic                in_last,
   output logic                in_ready,
   output logic [WIDTH-1:0]    num_o,
   output logic                start_o,
   input  logic                finished_i,
   input  logic [RESULT_W-1:0] result_i,
   output logic                finder_clr_o,
   output logic [SUM_W-1:0]    total_o,
   output logic [15:0]         lines_o,
   output logic                overflow_o,
`ifdef LINE_PACKER_WDOG_EN
   output logic                wdog_err_o,
`endif
   output logic                done_o
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);

   state_t             state;
   logic [WIDTH-1:0]   num;
   logic [CNT_W-1:0]   count;
   logic               eof_pend;
`ifdef LINE_PACKER_WDOG_EN
   logic [15:0]        wdog_cnt;
`endif

   logic accept;
   logic digit;
   logic take_digit;
   logic line_nonempty;

   assign accept        = in_valid && in_ready;
   assign digit         = is_digit(in_data);
   assign take_digit    = accept && digit && (count < CNT_W'(MAX_DIGITS));
   // Line is non-empty once this byte is counted; used for the in_last decision
   assign line_nonempty = (count != '0) || take_digit;

   assign num_o = num;

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_COLLECT;
         num          <= '0;
         count        <= '0;
         eof_pend     <= 1'b0;
         in_ready     <= 1'b1;
         start_o      <= 1'b0;
         finder_clr_o <= 1'b0;
         total_o      <= '0;
         lines_o      <= '0;
         overflow_o   <= 1'b0;
         done_o       <= 1'b0;
`ifdef LINE_PACKER_WDOG_EN
         wdog_cnt     <= '0;
         wdog_err_o   <= 1'b0;
`endif
      end else begin
         // NOTE: pulse outputs default low each cycle; only the transition
         // that needs them raises them for exactly one cycle.
         start_o      <= 1'b0;
         finder_clr_o <= 1'b0;

         case (state)
            ST_COLLECT: begin
               if (accept) begin
                  if (take_digit) begin
                     num   <= {num[WIDTH-5:0], in_data[3:0]};
                     count <= count + 1'b1;
                  end else if (digit) begin
                     overflow_o <= 1'b1;
                  end

                  if (in_last) begin
                     eof_pend <= 1'b1;
                     in_ready <= 1'b0;
                     if (line_nonempty) begin
                        state   <= ST_ISSUE;
                        start_o <= 1'b1;
                     end else begin
                        state  <= ST_FINAL;
                        done_o <= 1'b1;
                     end
                  end else if (in_data == CH_LF && count != '0) begin
                     state    <= ST_ISSUE;
                     start_o  <= 1'b1;
                     in_ready <= 1'b0;
                  end
               end
            end

            ST_ISSUE: begin
               state <= ST_WAIT;
`ifdef LINE_PACKER_WDOG_EN
               wdog_cnt <= '0;
`endif
            end

            ST_WAIT: begin
               if (finished_i) begin
                  total_o      <= total_o + SUM_W'(result_i);
                  lines_o      <= lines_o + 1'b1;
                  state        <= ST_CLEAR;
                  finder_clr_o <= 1'b1;
               end
`ifdef LINE_PACKER_WDOG_EN
               else if (wdog_cnt == 16'(WDOG_CYCLES - 1)) begin
                  // Finder never answered: skip the line without adding
                  wdog_err_o   <= 1'b1;
                  state        <= ST_CLEAR;
                  finder_clr_o <= 1'b1;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
`endif
            end

            ST_CLEAR: begin
               num   <= '0;
               count <= '0;
               if (eof_pend) begin
                  state  <= ST_FINAL;
                  done_o <= 1'b1;
               end else begin
                  state    <= ST_COLLECT;
                  in_ready <= 1'b1;
               end
            end

            ST_FINAL: begin
               state <= ST_FINAL;
            end

            default: begin
               state    <= ST_COLLECT;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
